// File: rtl/pri_enc_queue_if.sv
// Request/offer bundle for pri_enc_queue: request lines in, one index offered out.
// Handshake: the index on out_idx transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_valid and out_idx hold.
interface pri_enc_queue_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         ovf;

    modport master (
        input  req_in,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pending,
        output ovf
    );

    modport slave (
        output req_in,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pending,
        input  ovf
    );
endinterface

// File: rtl/pri_enc_queue.sv
// Latching priority encoder: accumulates requests into a pending vector and drains
// one index per accepted transfer, using LSB-first, MSB-first or round-robin order.
module pri_enc_queue #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    pri_enc_queue_if.master bus,
    output logic           o_dbg_state
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_rr_ptr;
    logic         r_ovf;

    logic         w_fire;
    logic [N-1:0] w_pop;
    logic [N-1:0] w_cand;
    logic         w_any;
    logic [W-1:0] w_ptr_nxt;
    logic [W-1:0] w_sel;
    logic [W-1:0] w_idx_nxt;

    assign w_fire = (r_state == OFFER) && bus.out_ready;
    assign w_pop  = w_fire ? (N'(1) << r_idx) : '0;
    assign w_cand = (r_pending & ~w_pop) | bus.req_in;
    assign w_any  = |w_cand;

    // The pointer advances on the same edge as the pop, so back-to-back selection uses the new value.
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_fire) begin
            w_ptr_nxt = (r_idx == W'(N - 1)) ? '0 : r_idx + W'(1);
        end
    end

    always_comb begin
        int j;
        w_sel = '0;
        j     = 0;
        if (MODE == 1) begin
            for (int i = 0; i < N; i++) begin
                if (w_cand[i]) w_sel = W'(i);
            end
        end else if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w_cand[i]) w_sel = W'(i);
            end
        end else begin
            // Scan from farthest to nearest so the nearest set bit at/after the pointer wins.
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(w_ptr_nxt) + k;
                if (j >= N) j = j - N;
                if (w_cand[j]) w_sel = W'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = OFFER;
                    w_idx_nxt   = w_sel;
                end
            end
            OFFER: begin
                if (bus.out_ready) begin
                    if (w_any) begin
                        w_idx_nxt = w_sel;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_cand;
            r_rr_ptr  <= w_ptr_nxt;
            r_ovf     <= |(bus.req_in & r_pending & ~w_pop);
        end
    end

    assign bus.out_valid = (r_state == OFFER);
    assign bus.out_idx   = r_idx;
    assign bus.pending   = r_pending;
    assign bus.ovf       = r_ovf;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_pri_enc_queue.sv
// Drives four pri_enc_queue instances (LSB, MSB, round-robin N=8, round-robin N=6) with
// shared stimulus and compares each against a bitmask reference model every cycle.
module tb_pri_enc_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tb_req;
  logic       tb_rdy;
  logic       dbg0, dbg1, dbg2, dbg3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pri_enc_queue_if #(.N(8)) bus0 ();
  pri_enc_queue_if #(.N(8)) bus1 ();
  pri_enc_queue_if #(.N(8)) bus2 ();
  pri_enc_queue_if #(.N(6)) bus3 ();

  assign bus0.req_in = tb_req;
  assign bus1.req_in = tb_req;
  assign bus2.req_in = tb_req;
  assign bus3.req_in = tb_req[5:0];
  assign bus0.out_ready = tb_rdy;
  assign bus1.out_ready = tb_rdy;
  assign bus2.out_ready = tb_rdy;
  assign bus3.out_ready = tb_rdy;

  pri_enc_queue #(.N(8), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_state(dbg0));
  pri_enc_queue #(.N(8), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(dbg1));
  pri_enc_queue #(.N(8), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .o_dbg_state(dbg2));
  pri_enc_queue #(.N(6), .MODE(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .o_dbg_state(dbg3));

  logic [7:0] o_pend [4];
  logic       o_val  [4];
  logic [2:0] o_idx  [4];
  logic       o_ovf  [4];

  assign o_pend[0] = bus0.pending;
  assign o_pend[1] = bus1.pending;
  assign o_pend[2] = bus2.pending;
  assign o_pend[3] = {2'b00, bus3.pending};
  assign o_val[0]  = bus0.out_valid;
  assign o_val[1]  = bus1.out_valid;
  assign o_val[2]  = bus2.out_valid;
  assign o_val[3]  = bus3.out_valid;
  assign o_idx[0]  = bus0.out_idx;
  assign o_idx[1]  = bus1.out_idx;
  assign o_idx[2]  = bus2.out_idx;
  assign o_idx[3]  = bus3.out_idx;
  assign o_ovf[0]  = bus0.ovf;
  assign o_ovf[1]  = bus1.ovf;
  assign o_ovf[2]  = bus2.ovf;
  assign o_ovf[3]  = bus3.ovf;

  // reference model state, one entry per instance
  int m_pend [4];
  int m_idx  [4];
  int m_ptr  [4];
  bit m_val  [4];
  bit m_ovf  [4];

  function automatic int n_of(input int i);
    return (i == 3) ? 6 : 8;
  endfunction

  function automatic int mode_of(input int i);
    return (i < 2) ? i : 2;
  endfunction

  function automatic int pick(input int cand, input int n, input int mode, input int ptr);
    if (mode == 0) begin
      for (int i = 0; i < n; i++) if (((cand >> i) & 1) == 1) return i;
    end else if (mode == 1) begin
      for (int i = n - 1; i >= 0; i--) if (((cand >> i) & 1) == 1) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (ptr + k) % n;
        if (((cand >> j) & 1) == 1) return j;
      end
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_idx[i]  = 0;
      m_ptr[i]  = 0;
      m_val[i]  = 1'b0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int n, req, pop, cand;
    bit fire;
    n    = n_of(i);
    req  = int'(tb_req) & ((1 << n) - 1);
    fire = m_val[i] && tb_rdy;
    pop  = fire ? (1 << m_idx[i]) : 0;
    m_ovf[i]  = ((req & m_pend[i] & ~pop) != 0);
    cand      = (m_pend[i] & ~pop) | req;
    if (fire) m_ptr[i] = (m_idx[i] + 1) % n;
    m_pend[i] = cand;
    if (!m_val[i] || tb_rdy) begin
      m_val[i] = (cand != 0);
      if (cand != 0) m_idx[i] = pick(cand, n, mode_of(i), m_ptr[i]);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_valid", i), 32'(o_val[i]), 32'(m_val[i]));
      if (m_val[i]) chk($sformatf("u%0d_idx", i), 32'(o_idx[i]), m_idx[i]);
      chk($sformatf("u%0d_pending", i), 32'(o_pend[i]), m_pend[i]);
      chk($sformatf("u%0d_ovf", i), 32'(o_ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  // inputs are applied at a falling edge; outputs are checked at the next falling edge
  task automatic cyc(input logic [7:0] req, input logic rdy);
    tb_req = req;
    tb_rdy = rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  // asserts reset between edges, checks the immediate clear, then releases at a falling edge
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n  = 1'b1;
    tb_req = 8'h00;
  endtask

  initial begin
    rst_n  = 1'b0;
    tb_req = 8'h00;
    tb_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk("reset_valid", 32'(bus0.out_valid), 32'd0);
    chk("reset_idx", 32'(bus0.out_idx), 32'd0);
    rst_n = 1'b1;

    // two simultaneous requests drained in each priority order
    cyc(8'h24, 1'b1);
    chk("lsb_first", 32'(bus0.out_idx), 32'd2);
    chk("msb_first", 32'(bus1.out_idx), 32'd5);
    cyc(8'h00, 1'b1);
    chk("lsb_second", 32'(bus0.out_idx), 32'd5);
    chk("msb_second", 32'(bus1.out_idx), 32'd2);
    chk("msb_pending", 32'(bus1.pending), 32'h04);
    cyc(8'h00, 1'b1);
    chk("lsb_drained", 32'(bus0.out_valid), 32'd0);
    chk("msb_drained", 32'(bus1.out_valid), 32'd0);

    // stall: a higher-priority arrival must not displace the frozen offer
    cyc(8'h24, 1'b0);
    chk("stall_offer", 32'(bus0.out_idx), 32'd2);
    cyc(8'h01, 1'b0);
    chk("stall_hold", 32'(bus0.out_idx), 32'd2);
    chk("stall_valid", 32'(bus0.out_valid), 32'd1);
    cyc(8'h00, 1'b1);
    chk("stall_next0", 32'(bus0.out_idx), 32'd0);
    cyc(8'h00, 1'b1);
    chk("stall_next5", 32'(bus0.out_idx), 32'd5);
    cyc(8'h00, 1'b1);
    chk("stall_done", 32'(bus0.out_valid), 32'd0);

    // duplicate request on an offered, stalled bit
    cyc(8'h08, 1'b0);
    chk("ovf_offer", 32'(bus0.out_idx), 32'd3);
    cyc(8'h08, 1'b0);
    chk("ovf_pulse", 32'(bus0.ovf), 32'd1);
    cyc(8'h00, 1'b0);
    chk("ovf_clear", 32'(bus0.ovf), 32'd0);
    cyc(8'h00, 1'b1);
    chk("ovf_once", 32'(bus0.out_valid), 32'd0);
    chk("ovf_once_pend", 32'(bus0.pending), 32'd0);
    // request coincident with its own pop is re-queued without overflow
    cyc(8'h08, 1'b1);
    cyc(8'h08, 1'b1);
    chk("requeue_valid", 32'(bus0.out_valid), 32'd1);
    chk("requeue_idx", 32'(bus0.out_idx), 32'd3);
    chk("requeue_ovf", 32'(bus0.ovf), 32'd0);
    cyc(8'h00, 1'b1);
    chk("requeue_done", 32'(bus0.out_valid), 32'd0);

    // reset in the middle of an offer
    cyc(8'hF0, 1'b0);
    chk("pre_reset_pend", 32'(bus0.pending), 32'hF0);
    async_reset();
    chk("rst_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_pend", 32'(bus0.pending), 32'd0);
    cyc(8'h00, 1'b1);
    chk("post_rst_idle", 32'(bus0.out_valid), 32'd0);
    chk("post_rst_idle_rr", 32'(bus2.out_valid), 32'd0);

    // round-robin sweep with every line held high
    for (int k = 0; k < 10; k++) begin
      cyc(8'hFF, 1'b1);
      chk($sformatf("rr8_seq%0d", k), 32'(bus2.out_idx), 32'(k % 8));
      chk($sformatf("rr8_valid%0d", k), 32'(bus2.out_valid), 32'd1);
      chk($sformatf("rr6_seq%0d", k), 32'(bus3.out_idx), 32'(k % 6));
    end
    repeat (10) cyc(8'h00, 1'b1);

    // random traffic with occasional resets
    for (int t = 0; t < 400; t++) begin
      logic [7:0] r;
      logic       rd;
      r  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      rd = ($urandom_range(0, 3) != 0);
      cyc(r, rd);
      if ($urandom_range(0, 99) == 0) async_reset();
    end
    repeat (12) cyc(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d_final_idle", i), 32'(o_val[i]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pri_enc_queue.md
# pri_enc_queue

Parametrised N-to-log2(N) encoder with request latching, selectable priority mode and a valid/ready output handshake. It succeeds the 4-to-2 combinational encoder in this codebase. Instead of requiring a one-hot input, it accumulates any number of concurrent requests and drains them one index per accepted transfer. It sits between interrupt/event sources and a downstream consumer that services one index at a time.

## Interface
- N, 8: number of request lines; N >= 2, not required to be a power of two.
- MODE, 0: 0 = fixed LSB-first priority, 1 = fixed MSB-first priority, 2 = round-robin.
- W (localparam): $clog2(N), the output index width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  N  request bits; each high bit sampled at a clk edge sets the matching pending bit.
- out_valid  out  1  an index is offered.
- out_ready  in  1  consumer accepts the offered index when out_valid && out_ready at a clk edge.
- out_idx  out  W  offered index; meaningful only when out_valid=1.
- pending  out  N  registered pending-request vector; the offered bit is included.
- ovf  out  1  one-cycle pulse when a request hit an already-pending bit.

## Operation
- Two-state FSM: IDLE (out_valid=0) and OFFER (out_valid=1). All outputs are registered.
- Per bit, the next pending value is (pending & ~pop) | req_in, where pop is the one-hot of out_idx when the transfer fires.
- A req_in bit equal to the popped index in the same cycle leaves that bit set: the index is re-queued, and ovf is not raised.
- Selection input: cand = (pending & ~pop) | req_in, evaluated each cycle.
- MODE 0 selects the lowest set bit of cand. MODE 1 selects the highest set bit.
- MODE 2 selects the first set bit at or after rr_ptr, wrapping from N-1 to 0. On every accepted transfer, rr_ptr becomes (out_idx+1) mod N; from N-1 it wraps to 0.
- IDLE -> OFFER when cand != 0. out_idx is loaded with the selection.
- OFFER with out_ready=0: stay in OFFER. out_idx is frozen even if a higher-priority request arrives; new requests only set pending.
- OFFER with out_ready=1 and cand != 0: stay in OFFER and load the next selection. This gives back-to-back transfers at one per cycle.
- OFFER with out_ready=1 and cand == 0: go to IDLE.
- out_ready while in IDLE has no effect.
- ovf is registered: it is 1 in the cycle after any edge where req_in[i] && pending[i] && !pop[i] for some i. The duplicate request is absorbed; the bit is still popped once.
- When N is not a power of 2, indices >= N are never produced.

## Timing
- Reset (rst_n=0) takes effect asynchronously and immediately: pending=0, out_valid=0, out_idx=0, ovf=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-offer drops the offered index and all pending requests; nothing is replayed.
- The first edge after reset release behaves as a normal cycle.
- Latency: a req_in sampled at edge k with the block in IDLE gives out_valid=1 with that index in the cycle after edge k (1 cycle).
- Throughput is one index per cycle while out_ready=1 and requests remain.
- out_valid must not drop while in OFFER until a transfer fires. out_idx must be stable while out_valid && !out_ready.
- The pending output reflects the register after each edge, so it lags req_in by one cycle.

## Test plan
- MODE 0, N=8: req_in=8'b0010_0100 for one cycle at edge 1, out_ready=1. Required: out_idx=2 after edge 1, out_idx=5 after edge 2, out_valid=0 after edge 3.
- MODE 1, N=8, same stimulus. Required: out_idx=5, then out_idx=2, then out_valid=0. pending=8'b0000_0100 after edge 2.
- Stall, MODE 0: while index 2 is offered with out_ready=0, pulse req_in=8'b0000_0001. Required: out_idx holds 2. After out_ready=1 the sequence is 2, 0, 5.
- MODE 2: req_in=8'hFF held continuously with out_ready=1. Required: out_idx sequence 0,1,...,7,0,1 and out_valid continuously 1. N=6 variant: sequence 0..5,0 with no index 6 or 7.
- Overflow: bit 3 offered and stalled, pulse req_in[3]. Required: ovf=1 for exactly one cycle and bit 3 accepted once. Separately, req_in[3] coincident with the pop of 3 gives re-offer of 3, ovf=0.
- Drop rst_n asynchronously mid-offer with pending=8'hF0. Required: out_valid=0 and pending=0 before the next clk edge. After release with req_in=0, out_valid stays 0.
